tlb_unit: RTL and testbench

TLB_UNIT -- requirements
Module: tlb_unit

---
 rtl/tlb_unit_pkg.sv | 70 +++++++
 rtl/tlb_unit_lookup.sv | 78 +++++++
 rtl/tlb_unit.sv | 214 +++++++++++++++++++++
 tb/tb_tlb_unit.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_unit_pkg.sv
// Shared TLB types, EntryLo/EntryHi field positions, segment bases, size codes.
// Imported by the TLB top and its lookup sub-module.
package tlb_unit_pkg;

    localparam int LO_PFN_LSB = 6;
    localparam int LO_C_LSB   = 3;
    localparam int LO_D       = 2;
    localparam int LO_V       = 1;
    localparam int LO_G       = 0;

    localparam logic [2:0] KSEG0_TOP = 3'b100;
    localparam logic [2:0] KSEG1_TOP = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        logic        present;
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        tlb_page_t   p1;
        tlb_page_t   p0;
    } tlb_entry_t;

    typedef enum logic [2:0] {
        FLT_NONE,
        FLT_ADDR,
        FLT_REFILL,
        FLT_INVALID,
        FLT_MOD
    } fault_e;

    function automatic logic entry_match(
        input tlb_entry_t  e,
        input logic [31:0] va,
        input logic [7:0]  asid
    );
        return e.present && (e.vpn2 == va[31:13]) && (e.g || (e.asid == asid));
    endfunction

    function automatic tlb_page_t lo_to_page(input logic [31:0] lo);
        tlb_page_t p;
        p.pfn = lo[LO_PFN_LSB +: 20];
        p.c   = lo[LO_C_LSB +: 3];
        p.d   = lo[LO_D];
        p.v   = lo[LO_V];
        return p;
    endfunction

    function automatic logic [31:0] page_to_lo(input tlb_page_t p, input logic g);
        logic [31:0] lo;
        lo = '0;
        lo[LO_PFN_LSB +: 20] = p.pfn;
        lo[LO_C_LSB +: 3]    = p.c;
        lo[LO_D]             = p.d;
        lo[LO_V]             = p.v;
        lo[LO_G]             = g;
        return lo;
    endfunction

endpackage

// File: rtl/tlb_unit_lookup.sv
// Combinational address translation for one port: match, lowest-index
// priority, page select, segment decode and fault classification.
module tlb_lookup
    import tlb_unit_pkg::*;
#(
    parameter int TLB_ENTRIES = 16
) (
    input  tlb_entry_t [TLB_ENTRIES-1:0] entries,
    input  logic                         req,
    input  logic [31:0]                  vaddr,
    input  logic [7:0]                   asid,
    input  logic                         user_mode,
    input  logic                         store,
    input  logic [1:0]                   size,
    output logic [31:0]                  paddr,
    output logic                         ok,
    output fault_e                       fault
);

    logic        hit;
    tlb_page_t   pg;
    logic        misaligned;
    logic        unmapped;
    logic        bad_addr;
    logic [31:0] pa;
    logic        unused_c;

    // scan downward so the lowest matching index is the one kept
    always_comb begin
        hit = 1'b0;
        pg  = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (entry_match(entries[i], vaddr, asid)) begin
                hit = 1'b1;
                pg  = vaddr[12] ? entries[i].p1 : entries[i].p0;
            end
        end
    end

    // alignment check by access size
    always_comb begin
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = vaddr[0];
            default: misaligned = |vaddr[1:0];
        endcase
    end

    assign unmapped = (vaddr[31:29] == KSEG0_TOP) || (vaddr[31:29] == KSEG1_TOP);
    assign bad_addr = misaligned || (user_mode && vaddr[31]);
    assign unused_c = ^pg.c;

    // fault priority: address error, refill, invalid, modify
    always_comb begin
        fault = FLT_NONE;
        pa    = '0;
        if (!req) begin
            fault = FLT_NONE;
        end else if (bad_addr) begin
            fault = FLT_ADDR;
        end else if (unmapped) begin
            pa = {3'b000, vaddr[28:0]};
        end else if (!hit) begin
            fault = FLT_REFILL;
        end else if (!pg.v) begin
            fault = FLT_INVALID;
        end else if (store && !pg.d) begin
            fault = FLT_MOD;
        end else begin
            pa = {pg.pfn, vaddr[11:0]};
        end
    end

    assign ok    = req && (fault == FLT_NONE);
    assign paddr = ok ? pa : '0;

endmodule

// File: rtl/tlb_unit.sv
// Joint TLB: TLBWI/TLBWR/TLBR/TLBP handling plus registered fetch and data
// translation with a single merged exception report.
module tlb_unit
    import tlb_unit_pkg::*;
#(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_pause_i,
    input  logic        instr_TLBWI_i,
    input  logic        instr_TLBWR_i,
    input  logic        instr_TLBR_i,
    input  logic        instr_TLBP_i,
    input  logic [31:0] cp0_index_i,
    input  logic [31:0] cp0_random_i,
    input  logic [31:0] cp0_entryhi_i,
    input  logic [31:0] cp0_entrylo0_i,
    input  logic [31:0] cp0_entrylo1_i,
    input  logic [31:0] cp0_status_i,
    input  logic        if_req_i,
    input  logic [31:0] if_vaddr_i,
    input  logic        mem_req_i,
    input  logic [31:0] mem_vaddr_i,
    input  logic        mem_rw_i,
    input  logic [1:0]  mem_size_i,
    output logic [31:0] if_paddr_o,
    output logic [31:0] mem_paddr_o,
    output logic        if_ok_o,
    output logic        mem_ok_o,
    output logic [3:0]  tlb_entryhi_match_index_o,
    output logic        tlb_entryhi_hit_o,
    output logic [31:0] cp0_entryhi_o,
    output logic [31:0] cp0_entrylo0_o,
    output logic [31:0] cp0_entrylo1_o,
    output logic        cp0_entryhi_data_valid_o,
    output logic        cp0_entrylo0_data_valid_o,
    output logic        cp0_entrylo1_data_valid_o,
    output logic        exception_addr_error_o,
    output logic        exception_tlb_refill_o,
    output logic        exception_tlb_invalid_o,
    output logic        exception_tlb_mod_o,
    output logic        exception_tlb_rw_o,
    output logic        exception_tlb_by_instr_o,
    output logic [31:0] cp0_bad_vaddr_o
);

    tlb_entry_t [TLB_ENTRIES-1:0] tlb;

    logic             user_mode;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    tlb_entry_t       new_entry;
    tlb_entry_t       rd_entry;
    logic             probe_hit;
    logic [3:0]       probe_idx;

    logic [31:0] if_pa;
    logic [31:0] mem_pa;
    logic        if_ok;
    logic        mem_ok;
    fault_e      if_fault;
    fault_e      mem_fault;
    fault_e      exc_fault;
    logic        if_exc;
    logic        mem_exc;
    logic        unused_bits;

    assign user_mode = cp0_status_i[4] & ~cp0_status_i[1];
    assign wr_en     = instr_TLBWI_i | instr_TLBWR_i;
    assign wr_idx    = instr_TLBWI_i ? cp0_index_i[IDX_W-1:0]
                                     : cp0_random_i[IDX_W-1:0];
    assign rd_idx    = cp0_index_i[IDX_W-1:0];
    assign rd_entry  = tlb[rd_idx];

    assign unused_bits = ^{cp0_index_i[31:IDX_W], cp0_random_i[31:IDX_W],
                           cp0_entryhi_i[12:8], cp0_entrylo0_i[31:26],
                           cp0_entrylo1_i[31:26], cp0_status_i[31:5],
                           cp0_status_i[3:2], cp0_status_i[0]};

    // entry image built from the CP0 staging registers
    always_comb begin
        new_entry         = '0;
        new_entry.present = 1'b1;
        new_entry.vpn2    = cp0_entryhi_i[31:13];
        new_entry.asid    = cp0_entryhi_i[7:0];
        new_entry.g       = cp0_entrylo0_i[LO_G] & cp0_entrylo1_i[LO_G];
        new_entry.p0      = lo_to_page(cp0_entrylo0_i);
        new_entry.p1      = lo_to_page(cp0_entrylo1_i);
    end

    // TLBP search, lowest matching index wins
    always_comb begin
        probe_hit = 1'b0;
        probe_idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (entry_match(tlb[i], cp0_entryhi_i, cp0_entryhi_i[7:0])) begin
                probe_hit = 1'b1;
                probe_idx = 4'(i);
            end
        end
    end

    tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES)) u_if_lookup (
        .entries   (tlb),
        .req       (if_req_i),
        .vaddr     (if_vaddr_i),
        .asid      (cp0_entryhi_i[7:0]),
        .user_mode (user_mode),
        .store     (1'b0),
        .size      (SZ_WORD),
        .paddr     (if_pa),
        .ok        (if_ok),
        .fault     (if_fault)
    );

    tlb_lookup #(.TLB_ENTRIES(TLB_ENTRIES)) u_mem_lookup (
        .entries   (tlb),
        .req       (mem_req_i),
        .vaddr     (mem_vaddr_i),
        .asid      (cp0_entryhi_i[7:0]),
        .user_mode (user_mode),
        .store     (mem_rw_i),
        .size      (mem_size_i),
        .paddr     (mem_pa),
        .ok        (mem_ok),
        .fault     (mem_fault)
    );

    assign mem_exc   = mem_fault != FLT_NONE;
    assign if_exc    = if_fault != FLT_NONE;
    assign exc_fault = mem_exc ? mem_fault : if_fault;

    // entry storage; lookups this cycle still see the old contents
    always_ff @(posedge clk) begin
        if (reset) begin
            tlb <= '0;
        end else if (!cpu_pause_i && wr_en) begin
            tlb[wr_idx] <= new_entry;
        end
    end

    // registered translation results
    always_ff @(posedge clk) begin
        if (reset) begin
            if_paddr_o  <= '0;
            mem_paddr_o <= '0;
            if_ok_o     <= 1'b0;
            mem_ok_o    <= 1'b0;
        end else if (!cpu_pause_i) begin
            if_paddr_o  <= if_pa;
            mem_paddr_o <= mem_pa;
            if_ok_o     <= if_ok;
            mem_ok_o    <= mem_ok;
        end
    end

    // single-cycle exception report, data side takes precedence
    always_ff @(posedge clk) begin
        if (reset) begin
            exception_addr_error_o   <= 1'b0;
            exception_tlb_refill_o   <= 1'b0;
            exception_tlb_invalid_o  <= 1'b0;
            exception_tlb_mod_o      <= 1'b0;
            exception_tlb_rw_o       <= 1'b0;
            exception_tlb_by_instr_o <= 1'b0;
            cp0_bad_vaddr_o          <= '0;
        end else if (!cpu_pause_i) begin
            exception_addr_error_o   <= exc_fault == FLT_ADDR;
            exception_tlb_refill_o   <= exc_fault == FLT_REFILL;
            exception_tlb_invalid_o  <= exc_fault == FLT_INVALID;
            exception_tlb_mod_o      <= exc_fault == FLT_MOD;
            exception_tlb_rw_o       <= mem_exc & mem_rw_i;
            exception_tlb_by_instr_o <= ~mem_exc & if_exc;
            if (mem_exc) begin
                cp0_bad_vaddr_o <= mem_vaddr_i;
            end else if (if_exc) begin
                cp0_bad_vaddr_o <= if_vaddr_i;
            end
        end
    end

    // TLBR readback and TLBP result
    always_ff @(posedge clk) begin
        if (reset) begin
            cp0_entryhi_o             <= '0;
            cp0_entrylo0_o            <= '0;
            cp0_entrylo1_o            <= '0;
            cp0_entryhi_data_valid_o  <= 1'b0;
            cp0_entrylo0_data_valid_o <= 1'b0;
            cp0_entrylo1_data_valid_o <= 1'b0;
            tlb_entryhi_hit_o         <= 1'b0;
            tlb_entryhi_match_index_o <= '0;
        end else if (!cpu_pause_i) begin
            cp0_entryhi_data_valid_o  <= instr_TLBR_i;
            cp0_entrylo0_data_valid_o <= instr_TLBR_i;
            cp0_entrylo1_data_valid_o <= instr_TLBR_i;
            if (instr_TLBR_i) begin
                cp0_entryhi_o  <= {rd_entry.vpn2, 5'b0, rd_entry.asid};
                cp0_entrylo0_o <= page_to_lo(rd_entry.p0, rd_entry.g);
                cp0_entrylo1_o <= page_to_lo(rd_entry.p1, rd_entry.g);
            end
            if (instr_TLBP_i) begin
                tlb_entryhi_hit_o <= probe_hit;
                if (probe_hit) begin
                    tlb_entryhi_match_index_o <= probe_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_tlb_unit.sv
// Self-checking bench for tlb_unit: directed literal cases plus randomized
// traffic compared every cycle against a behavioural TLB model.
module tb_tlb_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_pause_i;
    logic        instr_TLBWI_i, instr_TLBWR_i, instr_TLBR_i, instr_TLBP_i;
    logic [31:0] cp0_index_i, cp0_random_i, cp0_entryhi_i;
    logic [31:0] cp0_entrylo0_i, cp0_entrylo1_i, cp0_status_i;
    logic        if_req_i;
    logic [31:0] if_vaddr_i;
    logic        mem_req_i;
    logic [31:0] mem_vaddr_i;
    logic        mem_rw_i;
    logic [1:0]  mem_size_i;
    logic [31:0] if_paddr_o, mem_paddr_o;
    logic        if_ok_o, mem_ok_o;
    logic [3:0]  tlb_entryhi_match_index_o;
    logic        tlb_entryhi_hit_o;
    logic [31:0] cp0_entryhi_o, cp0_entrylo0_o, cp0_entrylo1_o;
    logic        cp0_entryhi_data_valid_o, cp0_entrylo0_data_valid_o;
    logic        cp0_entrylo1_data_valid_o;
    logic        exception_addr_error_o, exception_tlb_refill_o;
    logic        exception_tlb_invalid_o, exception_tlb_mod_o;
    logic        exception_tlb_rw_o, exception_tlb_by_instr_o;
    logic [31:0] cp0_bad_vaddr_o;

    always #5 clk = ~clk;

    tlb_unit #(.TLB_ENTRIES(16), .IDX_W(4)) dut (
        .clk(clk), .reset(reset), .cpu_pause_i(cpu_pause_i),
        .instr_TLBWI_i(instr_TLBWI_i), .instr_TLBWR_i(instr_TLBWR_i),
        .instr_TLBR_i(instr_TLBR_i), .instr_TLBP_i(instr_TLBP_i),
        .cp0_index_i(cp0_index_i), .cp0_random_i(cp0_random_i),
        .cp0_entryhi_i(cp0_entryhi_i), .cp0_entrylo0_i(cp0_entrylo0_i),
        .cp0_entrylo1_i(cp0_entrylo1_i), .cp0_status_i(cp0_status_i),
        .if_req_i(if_req_i), .if_vaddr_i(if_vaddr_i),
        .mem_req_i(mem_req_i), .mem_vaddr_i(mem_vaddr_i),
        .mem_rw_i(mem_rw_i), .mem_size_i(mem_size_i),
        .if_paddr_o(if_paddr_o), .mem_paddr_o(mem_paddr_o),
        .if_ok_o(if_ok_o), .mem_ok_o(mem_ok_o),
        .tlb_entryhi_match_index_o(tlb_entryhi_match_index_o),
        .tlb_entryhi_hit_o(tlb_entryhi_hit_o),
        .cp0_entryhi_o(cp0_entryhi_o), .cp0_entrylo0_o(cp0_entrylo0_o),
        .cp0_entrylo1_o(cp0_entrylo1_o),
        .cp0_entryhi_data_valid_o(cp0_entryhi_data_valid_o),
        .cp0_entrylo0_data_valid_o(cp0_entrylo0_data_valid_o),
        .cp0_entrylo1_data_valid_o(cp0_entrylo1_data_valid_o),
        .exception_addr_error_o(exception_addr_error_o),
        .exception_tlb_refill_o(exception_tlb_refill_o),
        .exception_tlb_invalid_o(exception_tlb_invalid_o),
        .exception_tlb_mod_o(exception_tlb_mod_o),
        .exception_tlb_rw_o(exception_tlb_rw_o),
        .exception_tlb_by_instr_o(exception_tlb_by_instr_o),
        .cp0_bad_vaddr_o(cp0_bad_vaddr_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // model TLB contents, one plain array per field
    bit          m_present [16];
    logic [31:0] m_vpn2 [16];
    logic [31:0] m_asid [16];
    logic [31:0] m_g [16];
    logic [31:0] m_pfn [16][2];
    logic [31:0] m_c [16][2];
    logic [31:0] m_d [16][2];
    logic [31:0] m_v [16][2];

    // model of every registered output
    logic [31:0] e_if_pa, e_mem_pa, e_idx, e_hi, e_lo0, e_lo1, e_bad;
    logic        e_if_ok, e_mem_ok, e_hit, e_rv;
    logic        e_ae, e_refill, e_inv, e_mod, e_rw, e_byi;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    // fault codes: 0 none, 1 address error, 2 refill, 3 invalid, 4 modify
    function automatic void mlook(input logic req, input logic [31:0] va,
                                  input logic st, input logic [1:0] sz,
                                  output int f, output logic [31:0] pa);
        int  hit;
        int  pg;
        bit  um;
        bit  mis;
        logic [31:0] vpn;
        f   = 0;
        pa  = 0;
        hit = -1;
        if (!req) return;
        um  = cp0_status_i[4] && !cp0_status_i[1];
        mis = (sz == 2'd1 && va % 2 != 0) || (sz >= 2'd2 && va % 4 != 0);
        if ((um && va >= 32'h8000_0000) || mis) begin
            f = 1;
            return;
        end
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) begin
            pa = va - 32'h8000_0000;
            return;
        end
        if (va >= 32'hA000_0000 && va < 32'hC000_0000) begin
            pa = va - 32'hA000_0000;
            return;
        end
        vpn = va / 8192;
        for (int i = 0; i < 16; i++) begin
            if (hit < 0 && m_present[i] && m_vpn2[i] == vpn &&
                (m_g[i] != 0 || m_asid[i] == cp0_entryhi_i % 256))
                hit = i;
        end
        pg = int'((va / 4096) % 2);
        if (hit < 0) f = 2;
        else if (m_v[hit][pg] == 0) f = 3;
        else if (st && m_d[hit][pg] == 0) f = 4;
        else pa = m_pfn[hit][pg] * 4096 + va % 4096;
    endfunction

    function automatic logic [31:0] mlo(input int ix, input int pg);
        return m_pfn[ix][pg] * 64 + m_c[ix][pg] * 8 + m_d[ix][pg] * 4 +
               m_v[ix][pg] * 2 + m_g[ix];
    endfunction

    task automatic mwrite(input int ix);
        logic [31:0] lo [2];
        lo[0] = cp0_entrylo0_i;
        lo[1] = cp0_entrylo1_i;
        m_present[ix] = 1'b1;
        m_vpn2[ix]    = cp0_entryhi_i / 8192;
        m_asid[ix]    = cp0_entryhi_i % 256;
        m_g[ix]       = (lo[0] % 2) * (lo[1] % 2);
        for (int p = 0; p < 2; p++) begin
            m_pfn[ix][p] = (lo[p] / 64) % (1 << 20);
            m_c[ix][p]   = (lo[p] / 8) % 8;
            m_d[ix][p]   = (lo[p] / 4) % 2;
            m_v[ix][p]   = (lo[p] / 2) % 2;
        end
    endtask

    // advance the model by one clock using the inputs currently applied
    task automatic model_eval();
        int fi, fm, k, ix, hit;
        logic [31:0] pi, pm;
        if (reset) begin
            for (int i = 0; i < 16; i++) m_present[i] = 1'b0;
            e_if_pa = 0; e_mem_pa = 0; e_idx = 0; e_hi = 0; e_lo0 = 0;
            e_lo1 = 0; e_bad = 0; e_if_ok = 0; e_mem_ok = 0; e_hit = 0;
            e_rv = 0; e_ae = 0; e_refill = 0; e_inv = 0; e_mod = 0;
            e_rw = 0; e_byi = 0;
            return;
        end
        if (cpu_pause_i) return;
        mlook(if_req_i, if_vaddr_i, 1'b0, 2'd2, fi, pi);
        mlook(mem_req_i, mem_vaddr_i, mem_rw_i, mem_size_i, fm, pm);
        e_if_ok  = if_req_i && fi == 0;
        e_if_pa  = e_if_ok ? pi : 0;
        e_mem_ok = mem_req_i && fm == 0;
        e_mem_pa = e_mem_ok ? pm : 0;
        k     = 0;
        e_rw  = 0;
        e_byi = 0;
        if (fm != 0) begin
            k = fm; e_rw = mem_rw_i; e_bad = mem_vaddr_i;
        end else if (fi != 0) begin
            k = fi; e_byi = 1; e_bad = if_vaddr_i;
        end
        e_ae = k == 1; e_refill = k == 2; e_inv = k == 3; e_mod = k == 4;
        e_rv = instr_TLBR_i;
        if (instr_TLBR_i) begin
            ix    = int'(cp0_index_i % 16);
            e_hi  = m_vpn2[ix] * 8192 + m_asid[ix];
            e_lo0 = mlo(ix, 0);
            e_lo1 = mlo(ix, 1);
        end
        if (instr_TLBP_i) begin
            hit = -1;
            for (int i = 0; i < 16; i++) begin
                if (hit < 0 && m_present[i] && m_vpn2[i] == cp0_entryhi_i / 8192 &&
                    (m_g[i] != 0 || m_asid[i] == cp0_entryhi_i % 256))
                    hit = i;
            end
            e_hit = hit >= 0;
            if (hit >= 0) e_idx = hit;
        end
        if (instr_TLBWI_i) mwrite(int'(cp0_index_i % 16));
        else if (instr_TLBWR_i) mwrite(int'(cp0_random_i % 16));
    endtask

    task automatic compare_all();
        chk("if_paddr", if_paddr_o, e_if_pa);
        chk1("if_ok", if_ok_o, e_if_ok);
        chk("mem_paddr", mem_paddr_o, e_mem_pa);
        chk1("mem_ok", mem_ok_o, e_mem_ok);
        chk("tlbp_index", {28'b0, tlb_entryhi_match_index_o}, e_idx);
        chk1("tlbp_hit", tlb_entryhi_hit_o, e_hit);
        chk("rd_entryhi", cp0_entryhi_o, e_hi);
        chk("rd_entrylo0", cp0_entrylo0_o, e_lo0);
        chk("rd_entrylo1", cp0_entrylo1_o, e_lo1);
        chk1("rd_hi_valid", cp0_entryhi_data_valid_o, e_rv);
        chk1("rd_lo0_valid", cp0_entrylo0_data_valid_o, e_rv);
        chk1("rd_lo1_valid", cp0_entrylo1_data_valid_o, e_rv);
        chk1("exc_addr", exception_addr_error_o, e_ae);
        chk1("exc_refill", exception_tlb_refill_o, e_refill);
        chk1("exc_invalid", exception_tlb_invalid_o, e_inv);
        chk1("exc_mod", exception_tlb_mod_o, e_mod);
        chk1("exc_rw", exception_tlb_rw_o, e_rw);
        chk1("exc_by_instr", exception_tlb_by_instr_o, e_byi);
        chk("bad_vaddr", cp0_bad_vaddr_o, e_bad);
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic clr();
        cpu_pause_i   = 0;
        instr_TLBWI_i = 0; instr_TLBWR_i = 0;
        instr_TLBR_i  = 0; instr_TLBP_i  = 0;
        if_req_i      = 0; if_vaddr_i    = 0;
        mem_req_i     = 0; mem_vaddr_i   = 0;
        mem_rw_i      = 0; mem_size_i    = 2'd2;
    endtask

    task automatic mem_acc(input logic [31:0] va, input logic st);
        mem_req_i   = 1;
        mem_vaddr_i = va;
        mem_rw_i    = st;
        mem_size_i  = 2'd2;
    endtask

    function automatic logic [18:0] pool_vpn(input int k);
        case (k)
            0: return 19'h00200;
            1: return 19'h00201;
            2: return 19'h00400;
            3: return 19'h7FFFF;
            default: return 19'h3FFFF;
        endcase
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        int k;
        a = $urandom;
        k = $urandom_range(0, 9);
        if (k < 6) a = {pool_vpn($urandom_range(0, 4)), a[12:0]};
        else if (k < 8) a[31:29] = (k == 6) ? 3'b100 : 3'b101;
        if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic rnd_cp0();
        cp0_index_i    = $urandom;
        cp0_random_i   = $urandom;
        cp0_entryhi_i  = {pool_vpn($urandom_range(0, 4)), 5'($urandom),
                          8'($urandom_range(0, 3))};
        cp0_entrylo0_i = $urandom;
        cp0_entrylo1_i = $urandom;
        if ($urandom_range(0, 3) != 0) cp0_entrylo0_i[1] = 1'b1;
        if ($urandom_range(0, 3) != 0) cp0_entrylo1_i[1] = 1'b1;
    endtask

    initial begin
        int s;
        clr();
        reset = 1;
        cp0_index_i = 0; cp0_random_i = 0; cp0_entryhi_i = 0;
        cp0_entrylo0_i = 0; cp0_entrylo1_i = 0; cp0_status_i = 0;
        step();
        step();
        chk1("reset_hit", tlb_entryhi_hit_o, 1'b0);
        chk1("reset_mem_ok", mem_ok_o, 1'b0);
        chk("reset_bad_vaddr", cp0_bad_vaddr_o, 32'h0);
        reset = 0;

        cp0_entryhi_i = 32'h0040_0005;
        clr(); mem_acc(32'h0040_0000, 0); step();
        chk1("empty_refill", exception_tlb_refill_o, 1'b1);
        chk1("empty_rw", exception_tlb_rw_o, 1'b0);
        chk("empty_bad", cp0_bad_vaddr_o, 32'h0040_0000);
        chk1("empty_ok", mem_ok_o, 1'b0);

        clr(); cp0_index_i = 3; cp0_entrylo0_i = 32'h0000_1006;
        cp0_entrylo1_i = 0; instr_TLBWI_i = 1; step();
        clr(); mem_acc(32'h0040_0010, 0); step();
        chk("wi_load_pa", mem_paddr_o, 32'h0004_0010);
        chk1("wi_load_ok", mem_ok_o, 1'b1);
        clr(); mem_acc(32'h0040_0010, 1); step();
        chk1("wi_store_dirty_ok", mem_ok_o, 1'b1);
        chk1("wi_store_no_mod", exception_tlb_mod_o, 1'b0);
        clr(); mem_acc(32'h0040_1000, 0); step();
        chk1("page1_invalid", exception_tlb_invalid_o, 1'b1);

        clr(); instr_TLBP_i = 1; step();
        chk1("tlbp_hit_lit", tlb_entryhi_hit_o, 1'b1);
        chk("tlbp_idx_lit", {28'b0, tlb_entryhi_match_index_o}, 32'd3);
        clr(); cp0_index_i = 3; instr_TLBR_i = 1; step();
        chk1("tlbr_valid_lit", cp0_entrylo0_data_valid_o, 1'b1);
        chk("tlbr_lo0_lit", cp0_entrylo0_o, 32'h0000_1006);
        chk("tlbr_hi_lit", cp0_entryhi_o, 32'h0040_0005);
        clr(); step();
        chk1("tlbr_valid_drop", cp0_entryhi_data_valid_o, 1'b0);
        clr(); cp0_entryhi_i = 32'h1234_5005; instr_TLBP_i = 1; step();
        chk1("tlbp_miss_hit", tlb_entryhi_hit_o, 1'b0);
        chk("tlbp_miss_idx", {28'b0, tlb_entryhi_match_index_o}, 32'd3);

        clr(); cp0_entryhi_i = 32'h0040_0006; mem_acc(32'h0040_0010, 0); step();
        chk1("asid_refill", exception_tlb_refill_o, 1'b1);
        clr(); cp0_entryhi_i = 32'h0040_0005; cp0_index_i = 3;
        cp0_entrylo0_i = 32'h0000_1007; cp0_entrylo1_i = 32'h1;
        instr_TLBWI_i = 1; step();
        clr(); cp0_entryhi_i = 32'h0040_0006; mem_acc(32'h0040_0010, 0); step();
        chk("global_pa", mem_paddr_o, 32'h0004_0010);
        chk1("global_ok", mem_ok_o, 1'b1);

        clr(); cp0_entryhi_i = 32'h0080_0006; cp0_index_i = 5;
        cp0_entrylo0_i = 32'h0000_2002; cp0_entrylo1_i = 0;
        instr_TLBWI_i = 1; step();
        clr(); mem_acc(32'h0080_0020, 1); step();
        chk1("mod_pulse", exception_tlb_mod_o, 1'b1);
        chk1("mod_rw", exception_tlb_rw_o, 1'b1);
        chk("mod_bad", cp0_bad_vaddr_o, 32'h0080_0020);

        clr(); cp0_entryhi_i = 32'h0040_0006; cp0_index_i = 1;
        cp0_entrylo0_i = 32'h0000_5002; instr_TLBWI_i = 1; step();
        clr(); mem_acc(32'h0040_0010, 0); step();
        chk("lowest_index_pa", mem_paddr_o, 32'h0014_0010);

        clr(); cp0_entryhi_i = 32'h00C0_0006; cp0_index_i = 7;
        cp0_entrylo0_i = 32'h0000_3006; instr_TLBWI_i = 1;
        mem_acc(32'h00C0_0000, 0); step();
        chk1("wr_same_cycle_refill", exception_tlb_refill_o, 1'b1);
        clr(); mem_acc(32'h00C0_0000, 0); step();
        chk("wr_after_pa", mem_paddr_o, 32'h000C_0000);

        clr(); if_req_i = 1; if_vaddr_i = 32'hBFC0_0002;
        mem_acc(32'h8000_1000, 0); step();
        chk("kseg0_pa", mem_paddr_o, 32'h0000_1000);
        chk1("kseg0_ok", mem_ok_o, 1'b1);
        chk1("fetch_ae", exception_addr_error_o, 1'b1);
        chk1("fetch_by_instr", exception_tlb_by_instr_o, 1'b1);
        chk("fetch_bad", cp0_bad_vaddr_o, 32'hBFC0_0002);

        clr(); cp0_status_i = 32'h10; mem_acc(32'h8000_0000, 0); step();
        chk1("user_ae", exception_addr_error_o, 1'b1);
        chk1("user_by_instr", exception_tlb_by_instr_o, 1'b0);
        cp0_status_i = 0;

        clr(); mem_acc(32'h0040_0010, 0); step();
        clr(); cpu_pause_i = 1; mem_acc(32'h8000_2000, 0);
        cp0_index_i = 1; cp0_entrylo0_i = 0; instr_TLBWI_i = 1; step();
        chk("pause_hold_pa", mem_paddr_o, 32'h0014_0010);
        step();
        chk1("pause_hold_ok", mem_ok_o, 1'b1);
        clr(); mem_acc(32'h0040_0010, 0); step();
        chk("pause_no_write", mem_paddr_o, 32'h0014_0010);

        for (int i = 0; i < 16; i++) begin
            clr(); rnd_cp0(); cp0_index_i = i; instr_TLBWI_i = 1; step();
        end
        for (int n = 0; n < 1500; n++) begin
            clr();
            rnd_cp0();
            cpu_pause_i   = $urandom_range(0, 9) == 0;
            s             = $urandom_range(0, 7);
            instr_TLBWI_i = s == 0;
            instr_TLBWR_i = s == 1;
            instr_TLBR_i  = s == 2;
            instr_TLBP_i  = s == 3;
            cp0_status_i  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0;
            if_req_i      = 1'($urandom_range(0, 1));
            if_vaddr_i    = rnd_addr();
            mem_req_i     = 1'($urandom_range(0, 1));
            mem_vaddr_i   = rnd_addr();
            mem_rw_i      = 1'($urandom_range(0, 1));
            mem_size_i    = 2'($urandom_range(0, 2));
            step();
        end

        clr(); cpu_pause_i = 1; reset = 1; instr_TLBP_i = 1;
        mem_acc(32'h0040_0010, 0); step();
        chk1("reset_over_pause_ok", mem_ok_o, 1'b0);
        chk1("reset_over_pause_hit", tlb_entryhi_hit_o, 1'b0);
        reset = 0;
        clr(); cp0_entryhi_i = 32'h0040_0006; mem_acc(32'h0040_0010, 0); step();
        chk1("reset_cleared_tlb", exception_tlb_refill_o, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
